mitchell_div_pipe: RTL

Pipelined Mitchell logarithmic approximate divider: the division counterpart of the team's Mitchell log multiplier, sharing its 9-bit sign-magnitude operand format and its LOD / priority-encode / barrel-normalise front end. It computes q ≈ x / y by subtracting the Mitchell log approximations and applying a signed antilog. The result is an unsigned Q8.8 magnitude plus sign. It sits in the datapath behind operand sources with a valid/ready handshake, three register stages deep, one result per cycle.

---
 rtl/mitchell_div_pkg.sv | 43 ++++
 rtl/mitchell_log_enc.sv | 29 ++
 rtl/mitchell_div_pipe.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mitchell_div_pkg.sv
// Shared widths, types and constants for the Mitchell logarithmic divider.
package mitchell_div_pkg;

  localparam int OPW  = 9;   // sign-magnitude operand width
  localparam int MAGW = 8;   // operand magnitude width
  localparam int KW   = 3;   // characteristic (leading-one position) width
  localparam int FW   = 7;   // mantissa width
  localparam int LW   = 11;  // log word: {guard, k, f}
  localparam int QW   = 16;  // Q8.8 quotient magnitude width

  // Magnitude reported when the divisor is zero.
  localparam logic [QW-1:0] Q_DIV0_MAG = 16'hFFFF;

  // Mitchell log approximation of one magnitude: k + f/128.
  typedef struct packed {
    logic [KW-1:0] k;
    logic [FW-1:0] f;
  } log_t;

  // Stage-1 register contents: both log words plus operand flags.
  typedef struct packed {
    logic [LW-1:0] op_a;
    logic [LW-1:0] op_b;
    logic          sign;
    logic          z_a;
    logic          z_b;
  } s1_t;

  // Stage-2 register contents: log difference plus operand flags.
  typedef struct packed {
    logic [LW-1:0] l;
    logic          sign;
    logic          z_a;
    logic          z_b;
  } s2_t;

  // Extend a log approximation to the 11-bit word used for subtraction;
  // the leading zero leaves headroom so the difference never overflows.
  function automatic logic [LW-1:0] log_word(input log_t v);
    return {1'b0, v.k, v.f};
  endfunction

endpackage

// File: rtl/mitchell_log_enc.sv
// Combinational Mitchell log encoder: leading-one detect, priority encode
// and barrel-normalise an 8-bit magnitude into characteristic and mantissa.
module mitchell_log_enc
  import mitchell_div_pkg::*;
(
  input  logic [MAGW-1:0] mag,
  output log_t            lg,
  output logic            zero
);

  logic [KW-1:0]   k;
  logic [MAGW-1:0] norm;

  // Find the highest set bit, then shift it up to bit 7 so the bits below
  // it become the fractional mantissa.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update so
    // no path leaves it unassigned and no latch is inferred.
    k = '0;
    for (int i = 0; i < MAGW; i++) begin
      if (mag[i]) k = KW'(i);
    end
    norm = mag << (KW'(MAGW - 1) - k);
  end

  assign lg   = '{k: k, f: norm[FW-1:0]};
  assign zero = (mag == '0);

endmodule

// File: rtl/mitchell_div_pipe.sv
// Three-stage pipelined Mitchell approximate divider with valid/ready
// handshake: log encode, log subtract, signed antilog.
module mitchell_div_pipe
  import mitchell_div_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [OPW-1:0] x_i,
  input  logic [OPW-1:0] y_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [QW:0]    q_o,
  output logic           div0_o
);

  // The whole pipe shares one enable: a result parked at the output freezes
  // every stage behind it, so nothing can be overwritten or dropped.
  logic stall;
  logic accept;

  assign stall      = out_valid_o & ~out_ready_i;
  assign in_ready_o = ~stall;
  assign accept     = in_valid_i & in_ready_o;

  // ---------------------------------------------------------------- stage 1
  log_t enc_a_lg;
  log_t enc_b_lg;
  logic enc_a_zero;
  logic enc_b_zero;
  s1_t  s1_d;
  s1_t  s1_q;
  logic s1_valid;

  mitchell_log_enc u_enc_a (
    .mag  (x_i[MAGW-1:0]),
    .lg   (enc_a_lg),
    .zero (enc_a_zero)
  );

  mitchell_log_enc u_enc_b (
    .mag  (y_i[MAGW-1:0]),
    .lg   (enc_b_lg),
    .zero (enc_b_zero)
  );

  assign s1_d = '{op_a: log_word(enc_a_lg),
                  op_b: log_word(enc_b_lg),
                  sign: x_i[OPW-1] ^ y_i[OPW-1],
                  z_a:  enc_a_zero,
                  z_b:  enc_b_zero};

  // Stage-1 valid follows the input handshake whenever the pipe moves.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every stage samples its predecessor's
    // value from before the edge, independent of block ordering.
    if (rst_i) begin
      s1_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= accept;
    end
  end

  // Stage-1 payload loads only with a real operand pair.
  always_ff @(posedge clk_i) begin
    // NOTE: payload registers carry no reset; the matching valid bit is
    // reset and qualifies them, which keeps the datapath flops cheap.
    if (!stall && accept) begin
      s1_q <= s1_d;
    end
  end

  // ---------------------------------------------------------------- stage 2
  s2_t  s2_d;
  s2_t  s2_q;
  logic s2_valid;

  // Dividing magnitudes is subtracting logs; 11-bit wraparound yields the
  // two's complement difference directly since |L| <= 1023.
  assign s2_d = '{l:    s1_q.op_a - s1_q.op_b,
                  sign: s1_q.sign,
                  z_a:  s1_q.z_a,
                  z_b:  s1_q.z_b};

  // Stage-2 valid advances from stage 1 whenever the pipe moves.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid <= 1'b0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
    end
  end

  // Stage-2 payload captures the log difference of a valid stage-1 entry.
  always_ff @(posedge clk_i) begin
    if (!stall && s1_valid) begin
      s2_q <= s2_d;
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic [3:0]    kq;        // signed characteristic, kept as raw bits
  logic [FW-1:0] fq;
  logic [MAGW-1:0] m;
  logic          kq_ge_m1;  // kq >= -1
  logic [3:0]    sh_left;   // kq + 1, valid when kq >= -1 (0..8)
  logic [3:0]    sh_right;  // -(kq + 1) == ~kq, valid when kq < -1 (1..7)
  logic [QW-1:0] shifted;
  logic [QW-1:0] mag;
  logic          sign_q;
  logic [QW:0]   q_d;

  // Signed antilog: restore the implicit one and shift it by the
  // characteristic relative to the Q8.8 binary point, truncating bits that
  // fall below it; then apply divide-by-zero and zero-dividend overrides.
  always_comb begin
    kq       = s2_q.l[LW-1:FW];
    fq       = s2_q.l[FW-1:0];
    m        = {1'b1, fq};
    kq_ge_m1 = !kq[3] || (kq == 4'b1111);
    sh_left  = kq + 4'd1;
    sh_right = ~kq;

    if (kq_ge_m1) begin
      shifted = QW'(m) << sh_left;
    end else begin
      shifted = QW'(m) >> sh_right;
    end

    if (s2_q.z_b) begin
      mag    = Q_DIV0_MAG;
      sign_q = s2_q.sign;
    end else if (s2_q.z_a) begin
      mag    = '0;
      sign_q = 1'b0;
    end else begin
      mag    = shifted;
      sign_q = s2_q.sign;
    end

    // A zero magnitude is always reported as positive zero.
    if (mag == '0) begin
      sign_q = 1'b0;
    end

    q_d = {sign_q, mag};
  end

  // Output register: reset clears everything; it holds while stalled and
  // otherwise takes the stage-2 result, leaving the payload alone on bubbles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      q_o         <= '0;
      div0_o      <= 1'b0;
    end else if (!stall) begin
      out_valid_o <= s2_valid;
      if (s2_valid) begin
        q_o    <= q_d;
        div0_o <= s2_q.z_b;
      end
    end
  end

endmodule
